sw_array_controller: RTL and testbench

SW_ARRAY_CONTROLLER -- requirements
Module: sw_array_controller

---
 rtl/sw_pkg.sv | 26 ++
 rtl/sw_array_controller_if.sv | 41 ++++
 rtl/sw_query_shreg.sv | 51 +++++
 rtl/sw_array_controller.sv | 151 +++++++++++++++
 tb/tb_sw_array_controller.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared constants, base codes and FSM encoding for the SW array controller
package sw_pkg;

  localparam int DEF_SCORE_WIDTH = 12;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_G = 2'b01,
    BASE_T = 2'b10,
    BASE_C = 2'b11
  } base_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  // Scores in the array are offset so that this value represents zero.
  function automatic int biased_zero(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/sw_array_controller_if.sv
// rtl/sw_array_controller_if.sv - query, target stream, array and result signals of the controller
interface sw_array_controller_if
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int N_PE        = 8,
  parameter int LEN_WIDTH   = 10
);

  logic                   q_wr;
  logic [1:0]             q_base;
  logic                   q_clr;
  logic                   start;
  logic                   t_valid;
  logic [1:0]             t_base;
  logic                   t_last;
  logic                   t_ready;
  logic                   pe_en;
  logic [1:0]             pe_data;
  logic [2*N_PE-1:0]      pe_query;
  logic                   pe_rst_n;
  logic                   arr_vld;
  logic [SCORE_WIDTH-1:0] arr_high;
  logic                   res_valid;
  logic                   res_ready;
  logic [SCORE_WIDTH-2:0] res_score;
  logic [LEN_WIDTH-1:0]   res_len;
  logic                   busy;
  logic                   err;

  modport master (
    output q_wr, q_base, q_clr, start, t_valid, t_base, t_last, arr_vld, arr_high, res_ready,
    input  t_ready, pe_en, pe_data, pe_query, pe_rst_n, res_valid, res_score, res_len, busy, err
  );

  modport slave (
    input  q_wr, q_base, q_clr, start, t_valid, t_base, t_last, arr_vld, arr_high, res_ready,
    output t_ready, pe_en, pe_data, pe_query, pe_rst_n, res_valid, res_score, res_len, busy, err
  );

endinterface

// File: rtl/sw_query_shreg.sv
// rtl/sw_query_shreg.sv - N_PE-slot query shift register with saturating fill count
module sw_query_shreg
  import sw_pkg::*;
#(
  parameter int N_PE = 8,
  parameter int CW   = $clog2(N_PE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              wr_i,
  input  logic              clr_i,
  input  logic [1:0]        base_i,
  output logic [2*N_PE-1:0] query_o,
  output logic [CW-1:0]     count_o
);

  logic [2*N_PE-1:0] query_q, query_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    query_d = query_q;
    count_d = count_q;
    if (en_i) begin
      if (clr_i) begin
        query_d = '0;
        count_d = '0;
      end else if (wr_i) begin
        // New base lands in slot 0; older bases move toward the last PE.
        query_d = {query_q[2*N_PE-3:0], base_i};
        if (count_q != CW'(N_PE)) begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query_q <= '0;
      count_q <= '0;
    end else begin
      query_q <= query_d;
      count_q <= count_d;
    end
  end

  assign query_o = query_q;
  assign count_o = count_q;

endmodule

// File: rtl/sw_array_controller.sv
// rtl/sw_array_controller.sv - job FSM feeding a Smith-Waterman PE chain and collecting its high score
module sw_array_controller
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int N_PE        = 8,
  parameter int LEN_WIDTH   = 10
) (
  input logic                  clk,
  input logic                  rst,
  sw_array_controller_if.slave bus
);

  localparam int CW  = $clog2(N_PE + 1);
  localparam int TMO = 4 * N_PE;
  localparam int TW  = $clog2(TMO);
  localparam logic [SCORE_WIDTH-1:0] BIAS    = SCORE_WIDTH'(biased_zero(SCORE_WIDTH));
  localparam logic [LEN_WIDTH-1:0]   LEN_SAT = '1;

  state_e state_q, state_d;

  logic                   pe_en_q;
  logic [1:0]             pe_data_q;
  logic                   pe_rst_n_q;
  logic                   err_q, err_d;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [SCORE_WIDTH-2:0] res_score_q;
  logic [LEN_WIDTH-1:0]   res_len_q;
  logic [TW-1:0]          tmo_q;
  logic                   flush_q;
  logic                   brk_q;

  logic [CW-1:0]          q_count;
  logic                   q_full;
  logic                   accept;
  logic                   len_ovf;
  logic                   last_beat;
  logic                   tmo_hit;
  logic                   t_ready_c, busy_c, res_valid_c;
  logic [SCORE_WIDTH-2:0] score_cap;

  sw_query_shreg #(.N_PE(N_PE), .CW(CW)) u_query (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (state_q == ST_IDLE),
    .wr_i    (bus.q_wr),
    .clr_i   (bus.q_clr),
    .base_i  (bus.q_base),
    .query_o (bus.pe_query),
    .count_o (q_count)
  );

  assign q_full    = (q_count == CW'(N_PE));
  assign accept    = (state_q == ST_STREAM) && bus.t_valid;
  // A beat that fills the length counter ends the job even without t_last.
  assign len_ovf   = (len_q == LEN_SAT - 1'b1);
  assign last_beat = accept && (bus.t_last || len_ovf);
  assign tmo_hit   = (tmo_q == TW'(TMO - 1));
  assign score_cap = (bus.arr_high >= BIAS) ? (SCORE_WIDTH-1)'(bus.arr_high - BIAS) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = (bus.start && q_full) ? ST_STREAM : ST_IDLE;
      ST_STREAM: begin
        if (!bus.t_valid)   state_d = ST_FLUSH;
        else if (last_beat) state_d = ST_DRAIN;
        else                state_d = ST_STREAM;
      end
      ST_DRAIN:  state_d = (bus.arr_vld || tmo_hit) ? ST_FLUSH : ST_DRAIN;
      ST_FLUSH: begin
        if (flush_q) state_d = brk_q ? ST_IDLE : ST_RESULT;
        else         state_d = ST_FLUSH;
      end
      ST_RESULT: state_d = bus.res_ready ? ST_IDLE : ST_RESULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    t_ready_c   = (state_q == ST_STREAM);
    busy_c      = (state_q != ST_IDLE);
    res_valid_c = (state_q == ST_RESULT);
    err_d       = ((state_q == ST_IDLE) && bus.start && !q_full)
               || ((state_q == ST_STREAM) && !bus.t_valid)
               || (accept && len_ovf && !bus.t_last)
               || ((state_q == ST_DRAIN) && !bus.arr_vld && tmo_hit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_en_q     <= 1'b0;
      pe_data_q   <= '0;
      pe_rst_n_q  <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      res_score_q <= '0;
      res_len_q   <= '0;
      tmo_q       <= '0;
      flush_q     <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      pe_en_q    <= accept;
      pe_rst_n_q <= (state_d != ST_FLUSH);
      err_q      <= err_d;
      tmo_q      <= (state_q == ST_DRAIN) ? tmo_q + 1'b1 : '0;
      flush_q    <= (state_q == ST_FLUSH) ? ~flush_q : 1'b0;
      if (accept) begin
        pe_data_q <= bus.t_base;
      end
      if ((state_q == ST_IDLE) && (state_d == ST_STREAM)) begin
        len_q <= '0;
      end else if (accept) begin
        len_q <= len_q + 1'b1;
      end
      if ((state_q == ST_STREAM) && !bus.t_valid) begin
        brk_q <= 1'b1;
      end else if (state_q == ST_IDLE) begin
        brk_q <= 1'b0;
      end
      if (state_q == ST_DRAIN) begin
        if (bus.arr_vld) begin
          res_score_q <= score_cap;
          res_len_q   <= len_q;
        end else if (tmo_hit) begin
          res_score_q <= '0;
          res_len_q   <= len_q;
        end
      end
    end
  end

  assign bus.t_ready   = t_ready_c;
  assign bus.busy      = busy_c;
  assign bus.res_valid = res_valid_c;
  assign bus.pe_en     = pe_en_q;
  assign bus.pe_data   = pe_data_q;
  assign bus.pe_rst_n  = pe_rst_n_q;
  assign bus.err       = err_q;
  assign bus.res_score = res_score_q;
  assign bus.res_len   = res_len_q;

endmodule

// File: tb/tb_sw_array_controller.sv
// tb/tb_sw_array_controller.sv - directed self-checking bench for sw_array_controller with N_PE=4
module tb_sw_array_controller;
  import sw_pkg::*;

  localparam int SW = 12;
  localparam int NP = 4;
  localparam int LW = 10;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   err_seen, rstn_low, rv_seen, busy_seen, tr_seen;
  logic [1:0] tgt [4];

  sw_array_controller_if #(.SCORE_WIDTH(SW), .N_PE(NP), .LEN_WIDTH(LW)) bus ();

  sw_array_controller #(.SCORE_WIDTH(SW), .N_PE(NP), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.err)       err_seen  <= err_seen + 1;
    if (!bus.pe_rst_n) rstn_low  <= rstn_low + 1;
    if (bus.res_valid) rv_seen   <= rv_seen + 1;
    if (bus.busy)      busy_seen <= busy_seen + 1;
    if (bus.t_ready)   tr_seen   <= tr_seen + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 300000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_base(input logic [1:0] b);
    bus.q_wr = 1'b1;
    bus.q_base = b;
    tick();
    bus.q_wr = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.res_valid) begin
      errors++;
      $display("FAIL wait_result: res_valid=%0b after %0d cycles, required 1", bus.res_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.t_ready !== 1'b0)   begin errors++; $display("FAIL rst_t_ready: got %0b want 0", bus.t_ready); end
    checks++; if (bus.pe_en !== 1'b0)     begin errors++; $display("FAIL rst_pe_en: got %0b want 0", bus.pe_en); end
    checks++; if (bus.pe_rst_n !== 1'b0)  begin errors++; $display("FAIL rst_pe_rst_n: got %0b want 0", bus.pe_rst_n); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %0b want 0", bus.res_valid); end
    checks++; if (bus.res_score !== '0)   begin errors++; $display("FAIL rst_res_score: got %0h want 0", bus.res_score); end
    checks++; if (bus.res_len !== '0)     begin errors++; $display("FAIL rst_res_len: got %0h want 0", bus.res_len); end
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %0b want 0", bus.err); end
    checks++; if (bus.pe_query !== 8'h00) begin errors++; $display("FAIL rst_pe_query: got %0h want 0", bus.pe_query); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.pe_rst_n !== 1'b1)  begin errors++; $display("FAIL rst_release_pe_rst_n: got %0b want 1", bus.pe_rst_n); end
  endtask

  task automatic test_query_load();
    load_base(BASE_A); load_base(BASE_C); load_base(BASE_G); load_base(BASE_T);
    checks++; if (bus.pe_query !== 8'h36) begin errors++; $display("FAIL query_acgt: got %0h want 36", bus.pe_query); end
    load_base(BASE_A);
    checks++; if (bus.pe_query !== 8'hD8) begin errors++; $display("FAIL query_shift5: got %0h want d8", bus.pe_query); end
    bus.q_clr = 1'b1;
    load_base(BASE_T);
    bus.q_clr = 1'b0;
    checks++; if (bus.pe_query !== 8'h00) begin errors++; $display("FAIL query_clr_priority: got %0h want 0", bus.pe_query); end
  endtask

  task automatic test_short_query();
    int e0, b0, t0;
    load_base(BASE_A); load_base(BASE_C); load_base(BASE_G);
    e0 = err_seen; b0 = busy_seen; t0 = tr_seen;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL short_err: got %0b want 1", bus.err); end
    repeat (4) tick();
    checks++; if (err_seen - e0 !== 1)  begin errors++; $display("FAIL short_err_count: got %0d want 1", err_seen - e0); end
    checks++; if (busy_seen - b0 !== 0) begin errors++; $display("FAIL short_busy: got %0d busy cycles want 0", busy_seen - b0); end
    checks++; if (tr_seen - t0 !== 0)   begin errors++; $display("FAIL short_t_ready: got %0d ready cycles want 0", tr_seen - t0); end
    load_base(BASE_T);
    checks++; if (bus.pe_query !== 8'h36) begin errors++; $display("FAIL short_reload: got %0h want 36", bus.pe_query); end
  endtask

  task automatic test_normal();
    int e0, r0, n;
    e0 = err_seen; r0 = rstn_low;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.t_ready !== 1'b1) begin errors++; $display("FAIL norm_stream: busy=%0b t_ready=%0b want 1 1", bus.busy, bus.t_ready); end
    for (int i = 0; i < 4; i++) begin
      bus.t_valid = 1'b1; bus.t_base = tgt[i]; bus.t_last = (i == 3);
      tick();
      checks++; if (bus.pe_en !== 1'b1 || bus.pe_data !== tgt[i]) begin errors++; $display("FAIL norm_beat%0d: pe_en=%0b pe_data=%0h want 1 %0h", i, bus.pe_en, bus.pe_data, tgt[i]); end
    end
    bus.t_valid = 1'b0; bus.t_last = 1'b0;
    checks++; if (bus.t_ready !== 1'b0) begin errors++; $display("FAIL norm_drain_t_ready: got %0b want 0", bus.t_ready); end
    tick();
    checks++; if (bus.pe_en !== 1'b0) begin errors++; $display("FAIL norm_pe_en_drop: got %0b want 0", bus.pe_en); end
    bus.arr_high = 12'h808; bus.arr_vld = 1'b1;
    tick();
    bus.arr_vld = 1'b0;
    wait_result(n);
    checks++; if (bus.res_score !== 11'd8) begin errors++; $display("FAIL norm_score: got %0d want 8", bus.res_score); end
    checks++; if (bus.res_len !== 10'd4)   begin errors++; $display("FAIL norm_len: got %0d want 4", bus.res_len); end
    checks++; if (err_seen - e0 !== 0)     begin errors++; $display("FAIL norm_no_err: got %0d pulses want 0", err_seen - e0); end
    checks++; if (rstn_low - r0 !== 2)     begin errors++; $display("FAIL norm_flush_len: got %0d want 2", rstn_low - r0); end
  endtask

  task automatic test_result_hold();
    int bad;
    bad = 0;
    bus.res_ready = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_score !== 11'd8 || bus.res_len !== 10'd4) bad++;
    end
    bus.start = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable: %0d unstable cycles want 0", bad); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL hold_release: busy=%0b res_valid=%0b want 0 0", bus.busy, bus.res_valid); end
  endtask

  task automatic test_protocol_break();
    int e0, r0, v0, n;
    e0 = err_seen; r0 = rstn_low; v0 = rv_seen;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.q_wr = 1'b1; bus.q_base = BASE_A;
    for (int i = 0; i < 2; i++) begin
      bus.t_valid = 1'b1; bus.t_base = tgt[i]; bus.t_last = 1'b0;
      tick();
    end
    bus.t_valid = 1'b0; bus.q_wr = 1'b0;
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL brk_err: got %0b want 1", bus.err); end
    n = 0;
    while (bus.busy && n < 10) begin tick(); n++; end
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL brk_idle: busy=%0b want 0", bus.busy); end
    checks++; if (rstn_low - r0 !== 2)    begin errors++; $display("FAIL brk_flush_len: got %0d want 2", rstn_low - r0); end
    checks++; if (rv_seen - v0 !== 0)     begin errors++; $display("FAIL brk_no_result: got %0d res_valid cycles want 0", rv_seen - v0); end
    checks++; if (err_seen - e0 !== 1)    begin errors++; $display("FAIL brk_err_count: got %0d want 1", err_seen - e0); end
    checks++; if (bus.pe_query !== 8'h36) begin errors++; $display("FAIL brk_query_kept: got %0h want 36", bus.pe_query); end
  endtask

  task automatic test_timeout();
    int n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.t_valid = 1'b1; bus.t_base = tgt[i]; bus.t_last = (i == 3);
      tick();
    end
    bus.t_valid = 1'b0; bus.t_last = 1'b0;
    n = 0;
    while (!bus.err && n < 40) begin tick(); n++; end
    checks++; if (n !== 16) begin errors++; $display("FAIL tmo_delay: err after %0d cycles want 16", n); end
    wait_result(n);
    checks++; if (bus.res_score !== 11'd0) begin errors++; $display("FAIL tmo_score: got %0d want 0", bus.res_score); end
    checks++; if (bus.res_len !== 10'd4)   begin errors++; $display("FAIL tmo_len: got %0d want 4", bus.res_len); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_len_saturation();
    int n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      bus.t_valid = 1'b1; bus.t_base = tgt[i % 4]; bus.t_last = 1'b0;
      tick();
    end
    bus.t_valid = 1'b0;
    checks++; if (bus.err !== 1'b1 || bus.t_ready !== 1'b0) begin errors++; $display("FAIL sat_end: err=%0b t_ready=%0b want 1 0", bus.err, bus.t_ready); end
    bus.arr_high = 12'h7FF; bus.arr_vld = 1'b1;
    tick();
    bus.arr_vld = 1'b0;
    wait_result(n);
    checks++; if (bus.res_score !== 11'd0)   begin errors++; $display("FAIL sat_clamp: got %0d want 0", bus.res_score); end
    checks++; if (bus.res_len !== 10'h3FF)   begin errors++; $display("FAIL sat_len: got %0d want 1023", bus.res_len); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.t_valid = 1'b1; bus.t_base = tgt[i]; bus.t_last = 1'b0;
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.pe_en !== 1'b0 || bus.t_ready !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_async: pe_en=%0b t_ready=%0b busy=%0b want 0 0 0", bus.pe_en, bus.t_ready, bus.busy); end
    checks++; if (bus.pe_data !== 2'b00 || bus.pe_rst_n !== 1'b0) begin errors++; $display("FAIL mid_rst_pe: pe_data=%0h pe_rst_n=%0b want 0 0", bus.pe_data, bus.pe_rst_n); end
    bus.t_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.pe_query !== 8'h00) begin errors++; $display("FAIL mid_rst_query: got %0h want 0", bus.pe_query); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_qcount: err=%0b busy=%0b want 1 0", bus.err, bus.busy); end
  endtask

  initial begin
    errors = 0; checks = 0;
    err_seen = 0; rstn_low = 0; rv_seen = 0; busy_seen = 0; tr_seen = 0;
    tgt[0] = BASE_A; tgt[1] = BASE_C; tgt[2] = BASE_G; tgt[3] = BASE_T;
    bus.q_wr = 1'b0; bus.q_base = 2'b00; bus.q_clr = 1'b0; bus.start = 1'b0;
    bus.t_valid = 1'b0; bus.t_base = 2'b00; bus.t_last = 1'b0;
    bus.arr_vld = 1'b0; bus.arr_high = '0; bus.res_ready = 1'b0;
    test_reset();
    test_query_load();
    test_short_query();
    test_normal();
    test_result_hold();
    test_protocol_break();
    test_timeout();
    test_len_saturation();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
